// File: rtl/exec_hazard_ctrl_pkg.sv
// exec_hazard_ctrl_pkg: shared encodings for the hazard controller.
package exec_hazard_ctrl_pkg;
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic REGFILE_SCALAR = 1'b0;
   localparam logic REGFILE_VECTOR = 1'b1;
   typedef enum logic [1:0] {IDLE = 2'd0, LSTALL = 2'd1, FLUSH = 2'd2} state_t;
endpackage

// File: rtl/exec_hazard_ctrl_fwd_select.sv
// exec_hazard_ctrl_fwd_select: ALU operand forward select for one source register.
module exec_hazard_ctrl_fwd_select
   import exec_hazard_ctrl_pkg::*;
(
   input  logic [4:0] i_rs,
   input  logic       i_rf_e,
   input  logic [4:0] i_rd_m,
   input  logic       i_wr_m,
   input  logic       i_rf_m,
   input  logic [4:0] i_rd_w,
   input  logic       i_wr_w,
   input  logic       i_rf_w,
   output logic [1:0] o_fwd
);
   logic w_ok, w_m, w_w;
   // scalar x0 is hardwired zero, vector v0 is a real register
   assign w_ok  = (i_rf_e == REGFILE_VECTOR) || (i_rs != 5'd0);
   assign w_m   = w_ok && i_wr_m && (i_rd_m == i_rs) && (i_rf_m == i_rf_e);
   assign w_w   = w_ok && i_wr_w && (i_rd_w == i_rs) && (i_rf_w == i_rf_e);
   assign o_fwd = w_m ? FWD_MEM : w_w ? FWD_WB : FWD_RF;
endmodule

// File: rtl/exec_hazard_ctrl.sv
// exec_hazard_ctrl: forwarding selects plus multi-cycle load-use stall / branch flush FSM.
// Optional HAZARD_PERF_EN adds saturating StallCount/FlushCount cycle counters.
module exec_hazard_ctrl
   import exec_hazard_ctrl_pkg::*;
#(
   parameter int STALL_CYCLES = 1,
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 4
)(
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] Rs1D,
   input  logic [4:0] Rs2D,
   input  logic       RegFileSelectD,
   input  logic [4:0] Rs1E,
   input  logic [4:0] Rs2E,
   input  logic [4:0] RdE,
   input  logic       RegFileSelectE,
   input  logic       RegWriteE,
   input  logic       ResultSrcE,
   input  logic       PCSrcE,
   input  logic [4:0] RdM,
   input  logic       RegWriteM,
   input  logic       RegFileSelectM,
   input  logic [4:0] RdW,
   input  logic       RegWriteW,
   input  logic       RegFileSelectW,
   output logic [1:0] ForwardAE,
   output logic [1:0] ForwardBE,
   output logic       StallF,
   output logic       StallD,
   output logic       FlushD,
   output logic       FlushE,
`ifdef HAZARD_PERF_EN
   output logic [31:0] StallCount,
   output logic [31:0] FlushCount,
`endif
   output logic       Busy
);
   localparam int L_MAX = (STALL_CYCLES > FLUSH_CYCLES) ? STALL_CYCLES : FLUSH_CYCLES;
   if (CNT_W < 1 || CNT_W > 30 || STALL_CYCLES < 1 || STALL_CYCLES > 15 ||
       FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15 || (2**CNT_W) - 1 < L_MAX) begin : g_bad_param
      $fatal(1, "exec_hazard_ctrl: STALL_CYCLES/FLUSH_CYCLES/CNT_W out of range");
   end
   localparam logic [CNT_W-1:0] L_STALL_LD = CNT_W'(STALL_CYCLES - 1);
   localparam logic [CNT_W-1:0] L_FLUSH_LD = CNT_W'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] L_ONE      = CNT_W'(1);
   state_t           r_state, w_next;
   logic [CNT_W-1:0] r_cnt, w_cnt;
   logic             w_lu, w_stall, w_flush;
   exec_hazard_ctrl_fwd_select u_fwd_a (
      .i_rs(Rs1E), .i_rf_e(RegFileSelectE),
      .i_rd_m(RdM), .i_wr_m(RegWriteM), .i_rf_m(RegFileSelectM),
      .i_rd_w(RdW), .i_wr_w(RegWriteW), .i_rf_w(RegFileSelectW),
      .o_fwd(ForwardAE)
   );
   exec_hazard_ctrl_fwd_select u_fwd_b (
      .i_rs(Rs2E), .i_rf_e(RegFileSelectE),
      .i_rd_m(RdM), .i_wr_m(RegWriteM), .i_rf_m(RegFileSelectM),
      .i_rd_w(RdW), .i_wr_w(RegWriteW), .i_rf_w(RegFileSelectW),
      .o_fwd(ForwardBE)
   );
   assign w_lu = ResultSrcE && RegWriteE && (RegFileSelectE == RegFileSelectD) &&
                 ((RdE == Rs1D) || (RdE == Rs2D)) &&
                 !((RegFileSelectD == REGFILE_SCALAR) && (RdE == 5'd0));
   always_comb begin
      w_next  = r_state;
      w_cnt   = r_cnt;
      w_stall = 1'b0;
      w_flush = 1'b0;
      case (r_state)
         IDLE: begin
            if (PCSrcE) begin
               w_flush = 1'b1;
               w_next  = (FLUSH_CYCLES > 1) ? FLUSH : IDLE;
               w_cnt   = L_FLUSH_LD;
            end else if (w_lu) begin
               w_stall = 1'b1;
               w_next  = (STALL_CYCLES > 1) ? LSTALL : IDLE;
               w_cnt   = L_STALL_LD;
            end
         end
         LSTALL: begin
            // a taken branch squashes the stalled instructions anyway
            if (PCSrcE) begin
               w_flush = 1'b1;
               w_next  = (FLUSH_CYCLES > 1) ? FLUSH : IDLE;
               w_cnt   = L_FLUSH_LD;
            end else begin
               w_stall = 1'b1;
               w_cnt   = r_cnt - L_ONE;
               w_next  = (r_cnt == L_ONE) ? IDLE : LSTALL;
            end
         end
         FLUSH: begin
            w_flush = 1'b1;
            w_cnt   = PCSrcE ? L_FLUSH_LD : r_cnt - L_ONE;
            w_next  = (!PCSrcE && r_cnt == L_ONE) ? IDLE : FLUSH;
         end
         default: begin
            w_next = IDLE;
            w_cnt  = '0;
         end
      endcase
   end
   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt;
      end
   end
   // controls are forced low while reset is held, independent of the inputs
   assign StallF = rst && w_stall;
   assign StallD = rst && w_stall;
   assign FlushD = rst && w_flush;
   assign FlushE = rst && (w_stall || w_flush);
   assign Busy   = (r_state != IDLE);
`ifdef HAZARD_PERF_EN
   logic [31:0] r_stall_cnt, r_flush_cnt;
   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (StallD && r_stall_cnt != 32'hFFFF_FFFF) r_stall_cnt <= r_stall_cnt + 32'd1;
         if (FlushD && r_flush_cnt != 32'hFFFF_FFFF) r_flush_cnt <= r_flush_cnt + 32'd1;
      end
   end
   assign StallCount = r_stall_cnt;
   assign FlushCount = r_flush_cnt;
`endif
endmodule

// File: doc/exec_hazard_ctrl.md
Name: exec_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 256-bit decode/execute/memory/writeback pipeline.
- Produces operand-forwarding selects for the execute-stage ALU inputs and stall/flush controls for the fetch, decode and execute pipeline registers.
- Runs a small FSM that stretches load-use stalls and branch flushes over multiple cycles.
- Sits beside the execute stage; consumes register addresses and control bits from D/E/M/W.

Parameters:
- STALL_CYCLES, 1, number of cycles F/D are held and E is bubbled on a load-use hazard (1..15).
- FLUSH_CYCLES, 1, number of cycles D/E are flushed after a taken branch (1..15).
- CNT_W, 4, width of the internal down-counter; must hold max(STALL_CYCLES, FLUSH_CYCLES).

Ports:
- clk  in  1  pipeline clock; state updates on the falling edge, aligned with the pipeline registers.
- rst  in  1  asynchronous, active-low reset.
- Rs1D, Rs2D  in  5  decode-stage source registers.
- RegFileSelectD  in  1  decode-stage register file: 0 = scalar, 1 = vector.
- Rs1E, Rs2E, RdE  in  5  execute-stage source and destination registers.
- RegFileSelectE  in  1  execute-stage register file select.
- RegWriteE  in  1  execute-stage write enable.
- ResultSrcE  in  1  1 = execute-stage instruction is a load.
- PCSrcE  in  1  taken branch resolved in execute.
- RdM  in  5  memory-stage destination register.
- RegWriteM  in  1  memory-stage write enable.
- RegFileSelectM  in  1  memory-stage register file select.
- RdW  in  5  writeback-stage destination register.
- RegWriteW  in  1  writeback-stage write enable.
- RegFileSelectW  in  1  writeback-stage register file select.
- ForwardAE, ForwardBE  out  2  ALU operand select: 00 = register file, 10 = ALUResultM, 01 = ResultW.
- StallF, StallD  out  1  hold the fetch/PC and decode registers.
- FlushD, FlushE  out  1  clear the decode/execute registers (insert bubble).
- Busy  out  1  FSM is not in IDLE.

Behaviour:
- Forwarding (combinational):
  - A source matches a stage when that stage's RegWrite=1, its Rd equals the source, and its RegFileSelect equals RegFileSelectE.
  - Register 0 never matches when the register file select is 0 (scalar x0 is hardwired zero); vector register 0 does forward.
  - M match wins over W match. No match gives 00. Identical rules for A (Rs1E) and B (Rs2E).
- Load-use detect: lu = ResultSrcE & RegWriteE & (RegFileSelectE==RegFileSelectD) & (RdE==Rs1D | RdE==Rs2D) & !(RegFileSelectD==0 & RdE==0).
- FSM states: IDLE, LSTALL, FLUSH. Counter cnt is CNT_W bits wide.
- IDLE:
  - If PCSrcE: FlushD=FlushE=1 this cycle. If FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-1.
  - Else if lu: StallF=StallD=FlushE=1 this cycle. If STALL_CYCLES>1, go to LSTALL with cnt=STALL_CYCLES-1.
- LSTALL: StallF=StallD=FlushE=1. Decrement cnt; return to IDLE when cnt reaches 1 at the clock edge. If PCSrcE asserts, abort the stall: drive flush outputs, go to FLUSH with cnt=FLUSH_CYCLES-1, or to IDLE if FLUSH_CYCLES=1.
- FLUSH: FlushD=FlushE=1, StallF=StallD=0. Decrement cnt; return to IDLE when cnt reaches 1. A new PCSrcE while in FLUSH reloads cnt=FLUSH_CYCLES-1.
- Simultaneous PCSrcE and lu in IDLE: flush wins; no stall is asserted.
- Outputs are combinational from state, cnt and inputs. Busy = (state != IDLE).
- Reset (asynchronous, any time, including mid-stall or mid-flush):
  - state=IDLE, cnt=0.
  - All stall/flush outputs and Busy = 0.
  - Forward selects remain a combinational function of the inputs.
- Counter never underflows: parameters are checked at elaboration; an out-of-range value is a fatal error.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined:
  - Adds outputs StallCount[31:0] and FlushCount[31:0], counting cycles with StallD=1 and cycles with FlushD=1 respectively.
  - Both counters saturate at 0xFFFFFFFF and are cleared by rst.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - the forward-select encodings FWD_RF=2'b00, FWD_MEM=2'b10, FWD_WB=2'b01;
  - the FSM state encodings (IDLE, LSTALL, FLUSH);
  - the REGFILE_SCALAR/REGFILE_VECTOR constants.
- One natural sub-module: fwd_select. It is combinational and instantiated twice, once for operand A and once for B, implementing the match and priority rules.

Test Plan:
- Forward priority: RdM=RdW=Rs1E=3, all RegWrite=1, all files scalar -> ForwardAE=10. Then RegWriteM=0 -> ForwardAE=01.
- x0 and file mismatch: scalar RdM=Rs2E=0 with RegWriteM=1 -> ForwardBE=00. Vector RdM=Rs2E=0 with RegFileSelectE=1 and RegFileSelectM=1 -> ForwardBE=10. RegFileSelectM=0 with RegFileSelectE=1 and equal addresses -> 00.
- Load-use with STALL_CYCLES=3: ResultSrcE=1, RdE=5, Rs1D=5 -> StallF=StallD=FlushE=1 for exactly 3 cycles, Busy=1 for the last 2, then IDLE.
- Branch with FLUSH_CYCLES=2, coinciding with lu -> FlushD=FlushE=1 for 2 cycles, StallF=StallD=0 throughout.
- Reset mid-LSTALL: drop rst in the 2nd stall cycle -> outputs 0 immediately (asynchronous); after release, state IDLE and no residual stall.
- HAZARD_PERF_EN: one 3-cycle stall plus one 2-cycle flush -> StallCount=3, FlushCount=2. Force StallCount to 0xFFFFFFFF and stall again -> value holds at 0xFFFFFFFF.
